// File: rtl/axi_lite_mem_responder_if.sv
// AXI4-Lite bus between the core (master) and the memory responder (slave).
// The read and write channels are grouped here so both ends share one port.
interface axi_lite_mem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_strb;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave memory model: independent read and write FSMs with fixed latency
// in front of a word array (Memory) that benches preload hierarchically.
module axi_lite_mem_responder #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned       RD_LAT     = 1,
  parameter int unsigned       WR_LAT     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  axi_lite_mem_responder_if.slave bus
);

  localparam int unsigned     DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] MEM_BYTES   = (ADDR_W+1)'(1) << (DEPTH_LOG2 + 2);
  localparam logic [15:0]     RD_CNT_INIT = 16'(RD_LAT - 1);
  localparam logic [15:0]     WR_CNT_INIT = 16'(WR_LAT - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_W-1:0] Memory [DEPTH];

  logic [1:0]        rState_q, rState_d;
  logic [15:0]       rCnt_q, rCnt_d;
  logic [ADDR_W-1:0] arAddr_q, arAddr_d;
  logic              arReady_q, arReady_d;
  logic              rValid_q, rValid_d;
  logic [DATA_W-1:0] rData_q, rData_d;
  logic [1:0]        rResp_q, rResp_d;

  logic [1:0]        wState_q, wState_d;
  logic [15:0]       wCnt_q, wCnt_d;
  logic [ADDR_W-1:0] awAddr_q, awAddr_d;
  logic [DATA_W-1:0] wData_q, wData_d;
  logic [3:0]        wStrb_q, wStrb_d;
  logic              awReady_q, awReady_d;
  logic              wReady_q, wReady_d;
  logic              awDone_q, awDone_d;
  logic              wDone_q, wDone_d;
  logic              bValid_q, bValid_d;
  logic [1:0]        bResp_q, bResp_d;

  logic [ADDR_W-1:0]     rdOff, wrOff;
  logic [DEPTH_LOG2-1:0] rdIndex, wrIndex;
  logic [1:0]            rdDecode, wrDecode;
  logic                  awHs, wHs, wCommit;
  logic                  unusedOffBits;

  // Offset is taken modulo 2^ADDR_W, so addresses below the base wrap high and hit DECERR.
  function automatic logic [1:0] decodeResp(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] off);
    if ((addr < BASE_ADDR) || ({1'b0, off} >= MEM_BYTES)) return RESP_DECERR;
    if (addr[1:0] != 2'b00) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign rdOff    = arAddr_q - BASE_ADDR;
  assign wrOff    = awAddr_q - BASE_ADDR;
  assign rdIndex  = rdOff[DEPTH_LOG2+1:2];
  assign wrIndex  = wrOff[DEPTH_LOG2+1:2];
  assign rdDecode = decodeResp(arAddr_q, rdOff);
  assign wrDecode = decodeResp(awAddr_q, wrOff);
  assign unusedOffBits = ^{rdOff[ADDR_W-1:DEPTH_LOG2+2], rdOff[1:0],
                           wrOff[ADDR_W-1:DEPTH_LOG2+2], wrOff[1:0]};

  assign awHs = bus.aw_valid & awReady_q;
  assign wHs  = bus.w_valid & wReady_q;

  always_comb begin
    rState_d  = rState_q;
    rCnt_d    = rCnt_q;
    arAddr_d  = arAddr_q;
    arReady_d = arReady_q;
    rValid_d  = rValid_q;
    rData_d   = rData_q;
    rResp_d   = rResp_q;
    case (rState_q)
      R_IDLE: begin
        arReady_d = 1'b1;
        if (bus.ar_valid && arReady_q) begin
          arAddr_d  = bus.ar_addr;
          arReady_d = 1'b0;
          rCnt_d    = RD_CNT_INIT;
          rState_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rCnt_q == 16'd0) begin
          rResp_d  = rdDecode;
          rData_d  = (rdDecode == RESP_OKAY) ? Memory[rdIndex] : '0;
          rValid_d = 1'b1;
          rState_d = R_RESP;
        end else begin
          rCnt_d = rCnt_q - 16'd1;
        end
      end
      R_RESP: begin
        if (bus.r_ready) begin
          rValid_d  = 1'b0;
          arReady_d = 1'b1;
          rState_d  = R_IDLE;
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // AW and W are captured independently; the latency count starts once both are held.
  always_comb begin
    wState_d  = wState_q;
    wCnt_d    = wCnt_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    awReady_d = awReady_q;
    wReady_d  = wReady_q;
    awDone_d  = awDone_q;
    wDone_d   = wDone_q;
    bValid_d  = bValid_q;
    bResp_d   = bResp_q;
    wCommit   = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (awHs) awAddr_d = bus.aw_addr;
        if (wHs) begin
          wData_d = bus.w_data;
          wStrb_d = bus.w_strb;
        end
        awDone_d  = awDone_q | awHs;
        wDone_d   = wDone_q | wHs;
        awReady_d = ~awDone_d;
        wReady_d  = ~wDone_d;
        if (awDone_d && wDone_d) begin
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          wCnt_d   = WR_CNT_INIT;
          wState_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wCnt_q == 16'd0) begin
          wCommit  = (wrDecode == RESP_OKAY);
          bResp_d  = wrDecode;
          bValid_d = 1'b1;
          wState_d = W_RESP;
        end else begin
          wCnt_d = wCnt_q - 16'd1;
        end
      end
      W_RESP: begin
        if (bus.b_ready) begin
          bValid_d  = 1'b0;
          awReady_d = 1'b1;
          wReady_d  = 1'b1;
          wState_d  = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rState_q  <= R_IDLE;
      rCnt_q    <= '0;
      arAddr_q  <= '0;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= '0;
      wState_q  <= W_IDLE;
      wCnt_q    <= '0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= '0;
    end else begin
      rState_q  <= rState_d;
      rCnt_q    <= rCnt_d;
      arAddr_q  <= arAddr_d;
      arReady_q <= arReady_d;
      rValid_q  <= rValid_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
      wState_q  <= wState_d;
      wCnt_q    <= wCnt_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      awReady_q <= awReady_d;
      wReady_q  <= wReady_d;
      awDone_q  <= awDone_d;
      wDone_q   <= wDone_d;
      bValid_q  <= bValid_d;
      bResp_q   <= bResp_d;
    end
  end

  // Memory sits outside the reset domain so its contents survive reset; a read
  // sampled on the commit edge still sees the old word.
  always_ff @(posedge clock) begin
    if (wCommit) begin
      for (int i = 0; i < 4; i++) begin
        if (wStrb_q[i]) Memory[wrIndex][8*i +: 8] <= wData_q[8*i +: 8];
      end
    end
  end

  assign bus.ar_ready = arReady_q;
  assign bus.r_valid  = rValid_q;
  assign bus.r_data   = rData_q;
  assign bus.r_resp   = rResp_q;
  assign bus.aw_ready = awReady_q;
  assign bus.w_ready  = wReady_q;
  assign bus.b_valid  = bValid_q;
  assign bus.b_resp   = bResp_q;

endmodule
